// File: rtl/rename_retire_queue_pkg.sv
// rtl/rename_retire_queue_pkg.sv - shared rename widths, tag type and retire entry layout
package rename_retire_queue_pkg;

  localparam int ROB_DEPTH      = 16;
  localparam int PHYS_REG_WIDTH = 6;
  localparam int ARCH_REG_WIDTH = 5;
  localparam int ROB_TAG_WIDTH  = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic                      uses_rw;
    logic [ARCH_REG_WIDTH-1:0] arch;
    logic [PHYS_REG_WIDTH-1:0] phys;
    logic [PHYS_REG_WIDTH-1:0] old_phys;
  } retire_entry_t;

endpackage

// File: rtl/rename_retire_queue_entry_ram.sv
// rtl/rename_retire_queue_entry_ram.sv - retire entry storage, one write port, two async reads
module retire_entry_ram
  import rename_retire_queue_pkg::*;
#(
  parameter  int DEPTH = ROB_DEPTH,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_addr,
  input  retire_entry_t wr_data,
  input  logic [TW-1:0] rd_a_addr,
  output retire_entry_t rd_a_data,
  input  logic [TW-1:0] rd_b_addr,
  output retire_entry_t rd_b_data
);

  // Payload needs no reset: the valid vector in the parent qualifies every read.
  retire_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = mem_q[rd_a_addr];
  assign rd_b_data = mem_q[rd_b_addr];

endmodule

// File: rtl/rename_retire_queue.sv
// rtl/rename_retire_queue.sv - in-order retire queue with commit/free and youngest-first flush rollback
module rename_retire_queue
  import rename_retire_queue_pkg::*;
#(
  parameter  int DEPTH     = ROB_DEPTH,
  parameter  int PHYS_REGS = 64,
  parameter  int ARCH_REGS = 32,
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int TW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  input  logic          alloc_uses_rw,
  input  logic [AW-1:0] alloc_arch,
  input  logic [PW-1:0] alloc_phys,
  input  logic [PW-1:0] alloc_old_phys,
  output logic [TW-1:0] alloc_tag,
  input  logic          wb_valid,
  input  logic [TW-1:0] wb_tag,
  input  logic          flush_valid,
  input  logic [TW-1:0] flush_tag,
  output logic          commit_valid,
  output logic [AW-1:0] commit_arch,
  output logic [PW-1:0] commit_phys,
  output logic          free_valid,
  output logic [PW-1:0] free_phys,
  output logic          restore_valid,
  output logic [AW-1:0] restore_arch,
  output logic [PW-1:0] restore_phys,
  output logic          rollback_busy,
  output logic [TW:0]   count
);

  typedef enum logic {NORMAL, ROLLBACK} state_e;

  localparam logic [TW:0] CNT_FULL = (TW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [TW-1:0]    head_q, head_d, tail_q, tail_d, flush_tag_q, flush_tag_d;
  logic [TW:0]      count_q, count_d;
  logic [DEPTH-1:0] done_q, done_d, valid_q, valid_d;
  logic [TW-1:0]    tail_m1;
  logic             do_alloc, do_retire;
  retire_entry_t    head_entry, tail_entry, wr_entry;

  assign tail_m1 = tail_q - TW'(1);
  assign wr_entry = '{uses_rw: alloc_uses_rw, arch: alloc_arch,
                      phys: alloc_phys, old_phys: alloc_old_phys};

  retire_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .wr_en     (do_alloc),
    .wr_addr   (tail_q),
    .wr_data   (wr_entry),
    .rd_a_addr (head_q),
    .rd_a_data (head_entry),
    .rd_b_addr (tail_m1),
    .rd_b_data (tail_entry)
  );

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    done_d        = done_q;
    valid_d       = valid_q;
    flush_tag_d   = flush_tag_q;
    commit_valid  = 1'b0;
    commit_arch   = '0;
    commit_phys   = '0;
    free_valid    = 1'b0;
    free_phys     = '0;
    restore_valid = 1'b0;
    restore_arch  = '0;
    restore_phys  = '0;
    do_retire     = 1'b0;
    alloc_ready   = (count_q < CNT_FULL) && (state_q == NORMAL) && !flush_valid;
    do_alloc      = alloc_valid && alloc_ready;

    case (state_q)
      NORMAL: begin
        if (flush_valid) begin
          flush_tag_d = flush_tag;
          state_d     = ROLLBACK;
        end else begin
          if ((count_q != '0) && done_q[head_q]) begin
            do_retire    = 1'b1;
            commit_valid = head_entry.uses_rw;
            free_valid   = head_entry.uses_rw;
            if (head_entry.uses_rw) begin
              commit_arch = head_entry.arch;
              commit_phys = head_entry.phys;
              free_phys   = head_entry.old_phys;
            end
          end
          if (wb_valid && valid_q[wb_tag]) begin
            done_d[wb_tag] = 1'b1;
          end
          // Clear after the write-back update so a retiring slot never keeps a stale done bit.
          if (do_retire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + TW'(1);
          end
          if (do_alloc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + TW'(1);
          end
          count_d = count_q + (TW+1)'(do_alloc) - (TW+1)'(do_retire);
        end
      end
      ROLLBACK: begin
        // Youngest first, so the last restore seen for an arch reg is its oldest mapping.
        if (tail_m1 != flush_tag_q) begin
          valid_d[tail_m1] = 1'b0;
          done_d[tail_m1]  = 1'b0;
          tail_d           = tail_m1;
          count_d          = count_q - (TW+1)'(1);
          restore_valid    = tail_entry.uses_rw;
          free_valid       = tail_entry.uses_rw;
          if (tail_entry.uses_rw) begin
            restore_arch = tail_entry.arch;
            restore_phys = tail_entry.old_phys;
            free_phys    = tail_entry.phys;
          end
        end else begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      done_q      <= '0;
      valid_q     <= '0;
      flush_tag_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      flush_tag_q <= flush_tag_d;
    end
  end

  assign alloc_tag     = tail_q;
  assign rollback_busy = (state_q == ROLLBACK);
  assign count         = count_q;

  flush_tag_in_queue_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == NORMAL && flush_valid) |-> valid_q[flush_tag]);

endmodule

// File: tb/tb_rename_retire_queue.sv
// tb/tb_rename_retire_queue.sv - directed and randomized checks against a queue-based reference model
module tb_rename_retire_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_valid = 1'b0, alloc_ready, alloc_uses_rw = 1'b0;
  logic [4:0] alloc_arch = '0;
  logic [5:0] alloc_phys = '0, alloc_old_phys = '0;
  logic [3:0] alloc_tag;
  logic       wb_valid = 1'b0;
  logic [3:0] wb_tag = '0;
  logic       flush_valid = 1'b0;
  logic [3:0] flush_tag = '0;
  logic       commit_valid, free_valid, restore_valid, rollback_busy;
  logic [4:0] commit_arch, restore_arch;
  logic [5:0] commit_phys, free_phys, restore_phys;
  logic [4:0] count;

  rename_retire_queue dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_uses_rw(alloc_uses_rw),
    .alloc_arch(alloc_arch), .alloc_phys(alloc_phys), .alloc_old_phys(alloc_old_phys),
    .alloc_tag(alloc_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_phys(commit_phys),
    .free_valid(free_valid), .free_phys(free_phys),
    .restore_valid(restore_valid), .restore_arch(restore_arch), .restore_phys(restore_phys),
    .rollback_busy(rollback_busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       uses;
    logic [4:0] arch;
    logic [5:0] phys;
    logic [5:0] old;
    logic       done;
    int         tag;
  } me_t;

  me_t rq[$];
  bit  rolling;
  int  ftag, next_tag;
  int  n_cmp = 0, n_err = 0;
  int  n_frees;

  logic       o_ready, o_cv, o_fv, o_rv, o_busy;
  logic [3:0] o_tag;
  logic [4:0] o_ca, o_ra, o_cnt;
  logic [5:0] o_cp, o_fp, o_rp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = 1'b0; wb_valid = 1'b0; flush_valid = 1'b0;
  endtask

  // One clock: compare combinational outputs mid-cycle against the model, then advance the model.
  task automatic step();
    bit         e_ready, do_ret, do_pop;
    logic       ecv, efv, erv;
    logic [4:0] eca, era;
    logic [5:0] ecp, efp, erp;
    me_t        e;
    ecv = 0; efv = 0; erv = 0; eca = 0; era = 0; ecp = 0; efp = 0; erp = 0;
    do_ret = 0; do_pop = 0;
    @(negedge clk);
    e_ready = (rq.size() < 16) && !rolling && !flush_valid;
    if (rolling) begin
      if (rq.size() > 0 && rq[rq.size()-1].tag != ftag) begin
        do_pop = 1;
        e = rq[rq.size()-1];
        if (e.uses) begin
          erv = 1; era = e.arch; erp = e.old; efv = 1; efp = e.phys;
        end
      end
    end else if (!flush_valid && rq.size() > 0 && rq[0].done) begin
      do_ret = 1;
      if (rq[0].uses) begin
        ecv = 1; eca = rq[0].arch; ecp = rq[0].phys; efv = 1; efp = rq[0].old;
      end
    end
    o_ready = alloc_ready; o_tag = alloc_tag; o_cv = commit_valid; o_ca = commit_arch;
    o_cp = commit_phys; o_fv = free_valid; o_fp = free_phys; o_rv = restore_valid;
    o_ra = restore_arch; o_rp = restore_phys; o_busy = rollback_busy; o_cnt = count;
    if (free_valid === 1'b1) n_frees++;
    chk("alloc_ready", alloc_ready, e_ready);
    chk("alloc_tag", alloc_tag, next_tag);
    chk("count", count, rq.size());
    chk("rollback_busy", rollback_busy, rolling);
    chk("commit_valid", commit_valid, ecv);
    chk("commit_arch", commit_arch, eca);
    chk("commit_phys", commit_phys, ecp);
    chk("free_valid", free_valid, efv);
    chk("free_phys", free_phys, efp);
    chk("restore_valid", restore_valid, erv);
    chk("restore_arch", restore_arch, era);
    chk("restore_phys", restore_phys, erp);
    @(posedge clk);
    if (rolling) begin
      if (do_pop) begin
        next_tag = rq[rq.size()-1].tag;
        void'(rq.pop_back());
      end else rolling = 0;
    end else if (flush_valid) begin
      rolling = 1; ftag = flush_tag;
    end else begin
      if (wb_valid) foreach (rq[i]) if (rq[i].tag == wb_tag) rq[i].done = 1;
      if (do_ret) void'(rq.pop_front());
      if (alloc_valid && e_ready) begin
        e = '{alloc_uses_rw, alloc_arch, alloc_phys, alloc_old_phys, 1'b0, next_tag};
        rq.push_back(e);
        next_tag = (next_tag + 1) % 16;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", rollback_busy, 0);
    chk("rst_valids", {commit_valid, free_valid, restore_valid}, 0);
    chk("rst_data", {commit_arch, commit_phys, free_phys, restore_arch, restore_phys}, 0);
    rq.delete(); rolling = 0; next_tag = 0; ftag = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic u, input logic [4:0] a, input logic [5:0] p, input logic [5:0] o);
    alloc_valid = 1; alloc_uses_rw = u; alloc_arch = a; alloc_phys = p; alloc_old_phys = o;
    step();
    alloc_valid = 0;
  endtask

  task automatic wb(input int t);
    wb_valid = 1; wb_tag = 4'(t);
    step();
    wb_valid = 0;
  endtask

  initial begin
    int arches[6];
    int guard;
    arches = '{2, 3, 4, 1, 6, 1};
    n_frees = 0;
    #2;
    do_reset();

    // Single instruction: commit(5,40), free(5)
    alloc(1, 5, 40, 5);
    wb(0);
    step();
    chk("t1_commit_valid", o_cv, 1);
    chk("t1_commit_arch", o_ca, 5);
    chk("t1_commit_phys", o_cp, 40);
    chk("t1_free_phys", o_fp, 5);
    step();
    chk("t1_count_after", o_cnt, 0);

    // Out-of-order write-back, in-order retire
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1, 5'(i + 1), 6'(10 + i), 6'(20 + i));
    for (int i = 3; i >= 0; i--) wb(i);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_retire_order", o_cp, 10 + i);
    end

    // Full queue: retire while full does not admit an alloc the same cycle
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1, 5'(i), 6'(i + 1), 6'(i + 32));
    wb(0);
    chk("t3_full_ready", o_ready, 0);
    alloc_valid = 1; alloc_uses_rw = 1; alloc_arch = 9; alloc_phys = 50; alloc_old_phys = 9;
    step();
    chk("t3_refused", o_ready, 0);
    chk("t3_retire", o_cv, 1);
    step();
    chk("t3_accepted", o_ready, 1);
    chk("t3_wrap_tag", o_tag, 0);
    alloc_valid = 0;
    step();
    chk("t3_count_full", o_cnt, 16);

    // Flush rollback pops 5,4,3 youngest first
    do_reset();
    for (int i = 0; i < 6; i++) alloc(1, 5'(arches[i]), 6'(30 + i), 6'(50 + i));
    flush_valid = 1; flush_tag = 2;
    step();
    flush_valid = 0;
    for (int i = 5; i >= 3; i--) begin
      step();
      chk("t4_free_phys", o_fp, 30 + i);
      chk("t4_restore_phys", o_rp, 50 + i);
    end
    chk("t4_final_restore_arch", o_ra, 1);
    step();
    step();
    chk("t4_count", o_cnt, 3);
    chk("t4_busy", o_busy, 0);

    // Flush suppresses same-cycle alloc and write-back
    do_reset();
    for (int i = 0; i < 3; i++) alloc(1, 5'(i + 7), 6'(i + 1), 6'(i + 8));
    alloc_valid = 1; wb_valid = 1; wb_tag = 0; flush_valid = 1; flush_tag = 2;
    step();
    idle();
    step();
    step();
    chk("t5_no_retire", o_cv, 0);
    chk("t5_count", o_cnt, 3);
    wb(0);
    step();
    chk("t5_retire_after_wb", o_cp, 1);

    // Wrap: 40 alloc/retire pairs
    do_reset();
    n_frees = 0;
    alloc(1, 0, 6'(0), 6'(63));
    for (int k = 1; k <= 40; k++) begin
      alloc_valid = 1; alloc_uses_rw = 1; alloc_arch = 5'(k % 32);
      alloc_phys = 6'(k % 64); alloc_old_phys = 6'((k + 20) % 64);
      wb_valid = 1; wb_tag = 4'((k - 1) % 16);
      step();
    end
    idle();
    wb(40 % 16);
    guard = 0;
    while (rq.size() > 0 && guard < 20) begin step(); guard++; end
    chk("t6_drain_bound", guard < 20, 1);
    chk("t6_free_count", n_frees, 41);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      alloc_valid = ($urandom_range(99) < 60);
      alloc_uses_rw = ($urandom_range(99) < 75);
      alloc_arch = 5'($urandom); alloc_phys = 6'($urandom); alloc_old_phys = 6'($urandom);
      wb_valid = ($urandom_range(99) < 55);
      wb_tag = 4'($urandom);
      flush_valid = 0;
      if (rq.size() > 0 && $urandom_range(99) < 6) begin
        flush_valid = 1;
        flush_tag = 4'(rq[$urandom_range(rq.size() - 1)].tag);
      end else if (rolling && $urandom_range(99) < 20) begin
        flush_valid = 1; flush_tag = 4'($urandom);
      end
      step();
    end
    idle();

    // Reset asserted in the middle of a rollback
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1, 5'(i), 6'(i + 10), 6'(i + 20));
    flush_valid = 1; flush_tag = 0;
    step();
    flush_valid = 0;
    step();
    chk("t7_in_rollback", o_busy, 1);
    do_reset();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
